fp_mul_seq: RTL and testbench

- Sequencing controller for the single/double-precision FP multiply path.
- Accepts an operand pair over a valid/ready handshake and classifies both operands.
- Special cases (NaN, infinity, zero, inf*zero) resolve locally in a fixed two cycles.
- All other operand pairs are issued to an external multi-cycle mantissa multiply core. The core result is collected and returned over an output valid/ready handshake, with a watchdog on the core.

---
 rtl/fp_mul_seq.sv | 131 +++++++++++++
 tb/tb_fp_mul_seq.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/fp_mul_seq.sv
// fp_mul_seq: FP multiply sequencer; resolves NaN/inf/zero locally, issues the rest to an external core with a watchdog.
// Define FP_MUL_SEQ_FTZ_EN to flush denormal operands to zero before classification.
module fp_mul_seq #(
    parameter int IS_DOUBLE   = 0,
    parameter int EXP_WIDTH   = IS_DOUBLE ? 11 : 8,
    parameter int MANT_WIDTH  = IS_DOUBLE ? 52 : 23,
    parameter int TOTAL_WIDTH = EXP_WIDTH + MANT_WIDTH + 1,
    parameter int TIMEOUT     = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [TOTAL_WIDTH-1:0] op1,
    input  logic [TOTAL_WIDTH-1:0] op2,
    output logic                   core_start,
    output logic [TOTAL_WIDTH-1:0] core_a,
    output logic [TOTAL_WIDTH-1:0] core_b,
    input  logic                   core_done,
    input  logic [TOTAL_WIDTH-1:0] core_result,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [TOTAL_WIDTH-1:0] result,
    output logic [3:0]             out_status,
    output logic                   out_timeout
);
    typedef enum logic [1:0] {IDLE, CLASS, CORE, OUT} state_t;
    localparam int CW = $clog2(TIMEOUT);
    localparam logic [TOTAL_WIDTH-1:0] QBIT = TOTAL_WIDTH'(1) << (MANT_WIDTH - 1);
    localparam logic [EXP_WIDTH-1:0] EONES = {EXP_WIDTH{1'b1}};
    localparam logic [TOTAL_WIDTH-1:0] TMO_RES = {1'b0, EONES, 1'b1, {(MANT_WIDTH-1){1'b0}}};

    state_t state, state_nx;
    logic [CW-1:0] cnt;
    logic cls_ph, special_q;
    logic [4:0] r1, r2, c1, c2;
    logic nan, inv, cinf, zro, special, sign;
    logic [TOTAL_WIDTH-1:0] spec_res;

    // {nan, inf, denormal, normal, zero}
    function automatic logic [4:0] classify(input logic [TOTAL_WIDTH-1:0] x);
        logic e1, e0, m0;
        e1 = &x[TOTAL_WIDTH-2:MANT_WIDTH];
        e0 = ~|x[TOTAL_WIDTH-2:MANT_WIDTH];
        m0 = ~|x[MANT_WIDTH-1:0];
        return {e1 & !m0, e1 & m0, e0 & !m0, !e1 & !e0, e0 & m0};
    endfunction

    assign r1 = classify(core_a);
    assign r2 = classify(core_b);
`ifdef FP_MUL_SEQ_FTZ_EN
    assign c1 = {r1[4:3], 1'b0, r1[1], r1[0] | r1[2]};
    assign c2 = {r2[4:3], 1'b0, r2[1], r2[0] | r2[2]};
`else
    assign c1 = r1;
    assign c2 = r2;
`endif

    assign nan  = c1[4] | c2[4];
    assign inv  = !nan & ((c1[3] & c2[0]) | (c1[0] & c2[3]));
    assign cinf = !nan & !inv & (c1[3] | c2[3]);
    assign zro  = !nan & !inv & !cinf & (c1[0] | c2[0]);
    // Only finite non-zero pairs (normal or surviving denormal) go to the core
    assign special = !((c1[1] | c1[2]) & (c2[1] | c2[2]));
    assign sign = core_a[TOTAL_WIDTH-1] ^ core_b[TOTAL_WIDTH-1];
    assign spec_res = nan  ? ((c1[4] ? core_a : core_b) | QBIT) :
                      inv  ? {1'b1, EONES, 1'b1, {(MANT_WIDTH-1){1'b0}}} :
                      cinf ? {sign, EONES, {MANT_WIDTH{1'b0}}} :
                             {sign, {(TOTAL_WIDTH-1){1'b0}}};

    assign in_ready   = state == IDLE;
    assign out_valid  = state == OUT;
    assign core_start = state == CORE && cnt == '0;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  state_nx = in_valid ? CLASS : IDLE;
            CLASS: state_nx = !cls_ph ? CLASS : special_q ? OUT : CORE;
            CORE:  state_nx = (core_done || cnt == CW'(TIMEOUT - 1)) ? OUT : CORE;
            OUT:   state_nx = out_ready ? IDLE : OUT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            cls_ph      <= 1'b0;
            special_q   <= 1'b0;
            core_a      <= '0;
            core_b      <= '0;
            result      <= '0;
            out_status  <= '0;
            out_timeout <= 1'b0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    cls_ph <= 1'b0;
                    if (in_valid) begin
                        core_a <= op1;
                        core_b <= op2;
                    end
                end
                // First CLASS cycle registers the classification, second one acts on it
                CLASS: begin
                    cls_ph <= 1'b1;
                    cnt    <= '0;
                    if (!cls_ph) begin
                        result     <= spec_res;
                        out_status <= {nan, cinf, zro, inv};
                        special_q  <= special;
                    end
                end
                CORE: begin
                    cnt <= cnt + 1'b1;
                    if (core_done) begin
                        result     <= core_result;
                        out_status <= 4'b0000;
                    end else if (cnt == CW'(TIMEOUT - 1)) begin
                        result      <= TMO_RES;
                        out_status  <= 4'b1000;
                        out_timeout <= 1'b1;
                    end
                end
                OUT: if (out_ready) out_timeout <= 1'b0;
            endcase
        end
    end
endmodule

// File: tb/tb_fp_mul_seq.sv
// tb_fp_mul_seq: scoreboard bench for fp_mul_seq (binary32, TIMEOUT=64) with a behavioural core responder.
module tb_fp_mul_seq;
    logic clk = 1'b0, rst_n = 1'b0;
    logic in_valid = 1'b0, out_ready = 1'b1, core_done = 1'b0;
    logic [31:0] op1 = '0, op2 = '0, core_result = '0;
    logic in_ready, core_start, out_valid, out_timeout;
    logic [31:0] core_a, core_b, result;
    logic [3:0] out_status;

    int n_cmp = 0, n_err = 0, n_start = 0, core_delay = -1;
    logic [31:0] core_val = '0, cap_a = '0, cap_b = '0;
    logic [36:0] exp_q[$];
    logic [36:0] e;

    fp_mul_seq dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op1(op1), .op2(op2), .core_start(core_start), .core_a(core_a), .core_b(core_b),
        .core_done(core_done), .core_result(core_result), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .out_status(out_status), .out_timeout(out_timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Core model: answers core_start after core_delay cycles (negative = never)
    initial forever begin
        @(negedge clk);
        if (core_start) begin
            n_start++;
            cap_a = core_a;
            cap_b = core_b;
            if (core_delay >= 0) begin
                repeat (core_delay) @(negedge clk);
                core_done = 1'b1;
                core_result = core_val;
                @(negedge clk);
                core_done = 1'b0;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) chk("unexpected_out", 1, 0);
            else begin
                e = exp_q.pop_front();
                chk("result", result, e[31:0]);
                chk("status", out_status, e[35:32]);
                chk("timeout", out_timeout, e[36]);
            end
        end
    end

    task automatic send(input logic [31:0] a, input logic [31:0] b);
        int g = 0;
        while (!in_ready && g < 200) begin @(posedge clk); #1; g++; end
        chk("accept_ready", in_ready, 1);
        in_valid = 1'b1; op1 = a; op2 = b;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (!out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
    endtask

    task automatic run(input logic [31:0] a, input logic [31:0] b, input logic [31:0] er,
                       input logic [3:0] es, input logic et, input int lat_exp, input int starts_exp);
        int s0, lat;
        s0 = n_start;
        exp_q.push_back({et, es, er});
        send(a, b);
        wait_out(lat);
        chk("latency", lat, lat_exp);
        @(posedge clk); #1;
        chk("core_starts", n_start - s0, starts_exp);
    endtask

    initial begin
        int lat;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_core_start", core_start, 0);
        chk("rst_result", result, 0);
        chk("rst_status", out_status, 0);
        chk("rst_core_a", core_a, 0);
        chk("rst_timeout", out_timeout, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run(32'h7F800000, 32'h00000000, 32'hFFC00000, 4'b0001, 1'b0, 2, 0);
        run(32'h00000000, 32'hFF800000, 32'hFFC00000, 4'b0001, 1'b0, 2, 0);
        run(32'h7F800001, 32'h3F800000, 32'h7FC00001, 4'b1000, 1'b0, 2, 0);
        run(32'h3F800000, 32'hFF800005, 32'hFFC00005, 4'b1000, 1'b0, 2, 0);
        run(32'h7F800002, 32'h7FC00003, 32'h7FC00002, 4'b1000, 1'b0, 2, 0);
        run(32'h7F800000, 32'h3F800000, 32'h7F800000, 4'b0100, 1'b0, 2, 0);
        run(32'h80000000, 32'h3F800000, 32'h80000000, 4'b0010, 1'b0, 2, 0);

        core_delay = 5; core_val = 32'h40000000;
        run(32'h3F800000, 32'h40000000, 32'h40000000, 4'b0000, 1'b0, 8, 1);
        chk("core_a", cap_a, 32'h3F800000);
        chk("core_b", cap_b, 32'h40000000);
        core_delay = 0; core_val = 32'h40400000;
        run(32'h3F800000, 32'h40400000, 32'h40400000, 4'b0000, 1'b0, 3, 1);

        core_delay = -1;
        run(32'h3F800000, 32'h40000000, 32'h7FC00000, 4'b1000, 1'b1, 66, 1);
        @(negedge clk); core_done = 1'b1; core_result = 32'h12345678;
        @(negedge clk); core_done = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("late_done_quiet", out_valid, 0);
        chk("late_done_ready", in_ready, 1);

`ifdef FP_MUL_SEQ_FTZ_EN
        run(32'h00000001, 32'hBF800000, 32'h80000000, 4'b0010, 1'b0, 2, 0);
`else
        core_delay = 2; core_val = 32'h80000001;
        run(32'h00000001, 32'hBF800000, 32'h80000001, 4'b0000, 1'b0, 5, 1);
`endif

        out_ready = 1'b0;
        exp_q.push_back({1'b0, 4'b0100, 32'hFF800000});
        send(32'hFF800000, 32'h3F800000);
        wait_out(lat);
        chk("hold_latency", lat, 2);
        in_valid = 1'b1; op1 = 32'h3F800000; op2 = 32'h3F800000;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("hold_result", result, 32'hFF800000);
            chk("hold_in_ready", in_ready, 0);
            chk("hold_valid", out_valid, 1);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("release_valid", out_valid, 0);
        chk("release_ready", in_ready, 1);

        core_delay = -1;
        send(32'h3F800000, 32'h40000000);
        repeat (6) @(posedge clk);
        #1;
        chk("mid_core_busy", in_ready, 0);
        rst_n = 1'b0;
        #1;
        chk("arst_in_ready", in_ready, 1);
        chk("arst_core_start", core_start, 0);
        chk("arst_out_valid", out_valid, 0);
        chk("arst_core_a", core_a, 0);
        chk("arst_core_b", core_b, 0);
        chk("arst_result", result, 0);
        chk("arst_status", out_status, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk); core_done = 1'b1; core_result = 32'h0BADF00D;
        @(negedge clk); core_done = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("post_rst_quiet", out_valid, 0);
        chk("post_rst_result", result, 0);

        core_delay = 1; core_val = 32'h40800000;
        run(32'h40000000, 32'h40000000, 32'h40800000, 4'b0000, 1'b0, 4, 1);
        chk("queue_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        repeat (20000) @(posedge clk);
        $display("FAIL watchdog: bench did not finish, got running expected done");
        $fatal(1);
    end
endmodule
